// File: rtl/fifo_halfword_burst_reader_pkg.sv
// Shared types and constants for the half-word burst reader.
package fifo_halfword_burst_reader_pkg;

    localparam int unsigned STATE_W = 2;

    typedef logic [STATE_W-1:0] half_burst_state_t;

    // Burst controller states
    localparam half_burst_state_t IDLE   = 2'd0;
    localparam half_burst_state_t RUN    = 2'd1;
    localparam half_burst_state_t FINISH = 2'd2;

endpackage

// File: rtl/fifo_halfword_burst_reader_if.sv
// Request, FIFO-side and output-stream signals of the half-word burst reader.
interface fifo_halfword_burst_reader_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned COUNTBITS = 16
);
    logic                 req_valid;
    logic                 req_ready;
    logic [COUNTBITS-1:0] req_halfwords;
    logic                 abort;
    logic [WIDTH-1:0]     fifo_dataout;
    logic                 fifo_valid;
    logic                 fifo_halfvalid;
    logic                 fifo_read;
    logic                 fifo_only_read_half;
    logic [WIDTH-1:0]     out_data;
    logic                 out_half;
    logic                 out_valid;
    logic                 out_ready;
    logic                 done;
    logic                 aborted;
    logic                 busy;
    logic [COUNTBITS-1:0] xfer_count;

    // Reader block view
    modport master (
        input  req_valid, req_halfwords, abort,
        input  fifo_dataout, fifo_valid, fifo_halfvalid, out_ready,
        output req_ready, fifo_read, fifo_only_read_half,
        output out_data, out_half, out_valid, done, aborted, busy, xfer_count
    );

    // Environment view: requester, FIFO and sink
    modport slave (
        output req_valid, req_halfwords, abort,
        output fifo_dataout, fifo_valid, fifo_halfvalid, out_ready,
        input  req_ready, fifo_read, fifo_only_read_half,
        input  out_data, out_half, out_valid, done, aborted, busy, xfer_count
    );
endinterface

// File: rtl/fifo_halfword_burst_reader_half_beat_out_reg.sv
// Valid/ready output register: load, hold while stalled, clear on accept.
// Half beats are stored with the upper half forced to zero.
module fifo_halfword_burst_reader_half_beat_out_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             half_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             half_o,
    output logic             valid_o
);
    localparam int unsigned HALF_W = WIDTH / 2;

    logic [WIDTH-1:0] data_q, data_d;
    logic             half_q, half_d;
    logic             valid_q, valid_d;

    // Next beat: a load always wins, otherwise an accepted beat empties the slot
    always_comb begin
        data_d  = data_q;
        half_d  = half_q;
        valid_d = valid_q;
        if (load_i) begin
            valid_d = 1'b1;
            half_d  = half_i;
            data_d  = half_i ? {{(WIDTH - HALF_W){1'b0}}, data_i[HALF_W-1:0]} : data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Beat register; reset discards any pending beat
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            half_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            half_q  <= half_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign half_o  = half_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fifo_halfword_burst_reader.sv
// Drains a requested number of half-words from a half-width-read FIFO,
// using full-word reads while two or more remain and a lower-half read for an odd tail.
module fifo_halfword_burst_reader
    import fifo_halfword_burst_reader_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned COUNTBITS = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    fifo_halfword_burst_reader_if.master  bus
);
    half_burst_state_t    state_q, state_d;
    logic [COUNTBITS-1:0] remaining_q, remaining_d;
    logic [COUNTBITS-1:0] xfer_q, xfer_d;
    logic                 abort_lat_q, abort_lat_d;
    logic                 done_q, done_d;
    logic                 aborted_q, aborted_d;
    logic                 busy_q, busy_d;
    logic                 req_ready_q, req_ready_d;

    logic                 slot_free_c;
    logic                 rd_c;
    logic                 rd_half_c;

    // The output slot can take a new beat when empty or being drained this cycle
    assign slot_free_c = !bus.out_valid || bus.out_ready;

    // Next-state, counters and read issue
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        xfer_d      = xfer_q;
        abort_lat_d = abort_lat_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        rd_c        = 1'b0;
        rd_half_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    xfer_d = '0;
                    if (bus.req_halfwords != '0) begin
                        remaining_d = bus.req_halfwords;
                        abort_lat_d = 1'b0;
                        state_d     = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    abort_lat_d = 1'b1;
                    state_d     = FINISH;
                end else if ((remaining_q >= COUNTBITS'(2)) && bus.fifo_valid && slot_free_c) begin
                    rd_c        = 1'b1;
                    remaining_d = remaining_q - COUNTBITS'(2);
                    xfer_d      = xfer_q + COUNTBITS'(2);
                    if (remaining_q == COUNTBITS'(2)) begin
                        state_d = FINISH;
                    end
                end else if ((remaining_q == COUNTBITS'(1)) && bus.fifo_halfvalid && slot_free_c) begin
                    rd_c        = 1'b1;
                    rd_half_c   = 1'b1;
                    remaining_d = '0;
                    xfer_d      = xfer_q + COUNTBITS'(1);
                    state_d     = FINISH;
                end
            end
            FINISH: begin
                if (slot_free_c) begin
                    done_d    = 1'b1;
                    aborted_d = abort_lat_q;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d      = (state_d != IDLE);
        req_ready_d = (state_d == IDLE);
    end

    // Controller state and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            xfer_q      <= '0;
            abort_lat_q <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            xfer_q      <= xfer_d;
            abort_lat_q <= abort_lat_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
        end
    end

    fifo_halfword_burst_reader_half_beat_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (rd_c),
        .half_i  (rd_half_c),
        .data_i  (bus.fifo_dataout),
        .ready_i (bus.out_ready),
        .data_o  (bus.out_data),
        .half_o  (bus.out_half),
        .valid_o (bus.out_valid)
    );

    assign bus.fifo_read           = rd_c;
    assign bus.fifo_only_read_half = rd_half_c;
    assign bus.req_ready           = req_ready_q;
    assign bus.done                = done_q;
    assign bus.aborted             = aborted_q;
    assign bus.busy                = busy_q;
    assign bus.xfer_count          = xfer_q;

endmodule

// File: tb/tb_fifo_halfword_burst_reader.sv
// Directed bench for the half-word burst reader with a half-word FIFO model and stream monitor.
module tb_fifo_halfword_burst_reader;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned CB    = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fifo_halfword_burst_reader_if #(.WIDTH(WIDTH), .COUNTBITS(CB)) bus ();

    fifo_halfword_burst_reader #(.WIDTH(WIDTH), .COUNTBITS(CB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    // FIFO model state (half-word granularity, lower half is the oldest)
    logic [15:0] hq[$];
    bit          fifo_en;
    bit          full_block;
    int          pop_n;

    // Monitor state
    logic [WIDTH:0] beats[$];
    int             beat_cyc[$];
    int             cyc_n = 0;
    int             n_full, n_half, done_cnt, done_cyc;
    logic           last_aborted;
    logic [CB-1:0]  last_xfer;

    task automatic refresh();
        bus.fifo_valid     = fifo_en && !full_block && (hq.size() >= 2);
        bus.fifo_halfvalid = fifo_en && (hq.size() >= 1);
        bus.fifo_dataout   = {(hq.size() >= 2) ? hq[1] : 16'h0, (hq.size() >= 1) ? hq[0] : 16'h0};
    endtask

    // FIFO model: retire what the DUT read at this edge, then present the new head
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < pop_n; i++) begin
            if (hq.size() > 0) void'(hq.pop_front());
        end
        refresh();
    end

    // Stream monitor, sampled mid-cycle
    always @(negedge clk) begin
        cyc_n++;
        pop_n = 0;
        if (bus.fifo_read === 1'b1) begin
            if (bus.fifo_only_read_half === 1'b1) begin
                pop_n = 1;
                n_half++;
            end else begin
                pop_n = 2;
                n_full++;
            end
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            beats.push_back({bus.out_half, bus.out_data});
            beat_cyc.push_back(cyc_n);
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc     = cyc_n;
            last_aborted = bus.aborted;
            last_xfer    = bus.xfer_count;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        beats.delete();
        beat_cyc.delete();
        n_full   = 0;
        n_half   = 0;
        done_cnt = 0;
        done_cyc = 0;
        last_aborted = 1'b0;
        last_xfer    = '0;
    endtask

    task automatic push_word(input logic [31:0] w);
        hq.push_back(w[15:0]);
        hq.push_back(w[31:16]);
    endtask

    task automatic issue_req(input int n);
        cyc();
        bus.req_valid     = 1'b1;
        bus.req_halfwords = CB'(n);
        cyc();
        bus.req_valid     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cyc();
        cyc();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        total++; if (bus.xfer_count !== 16'd0) begin bad++; $display("FAIL reset_xfer got=%0d want=0", bus.xfer_count); end
        total++; if (bus.out_data !== 32'd0) begin bad++; $display("FAIL reset_out_data got=%h want=0", bus.out_data); end
        total++; if (bus.fifo_read !== 1'b0) begin bad++; $display("FAIL reset_fifo_read got=%b want=0", bus.fifo_read); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", bus.req_ready); end
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_full_words();
        logic [31:0] w[3];
        bit seen;
        w = '{32'h0A0B0C0D, 32'h11223344, 32'h55667788};
        hq.delete();
        clear_mon();
        for (int i = 0; i < 3; i++) push_word(w[i]);
        bus.out_ready = 1'b1;
        issue_req(6);
        wait_done(50, seen);
        total++; if (!seen) begin bad++; $display("FAIL full_done_timeout got=0 want=1"); end
        cyc();
        cyc();
        total++; if (beats.size() != 3) begin bad++; $display("FAIL full_beat_count got=%0d want=3", beats.size()); end
        for (int i = 0; i < 3; i++) begin
            total++; if (beats[i] !== {1'b0, w[i]}) begin bad++; $display("FAIL full_beat%0d got=%h want=%h", i, beats[i], {1'b0, w[i]}); end
        end
        total++; if (n_full != 3 || n_half != 0) begin bad++; $display("FAIL full_reads got=%0d/%0d want=3/0", n_full, n_half); end
        total++; if (last_xfer !== 16'd6) begin bad++; $display("FAIL full_xfer got=%0d want=6", last_xfer); end
        total++; if (last_aborted !== 1'b0) begin bad++; $display("FAIL full_aborted got=%b want=0", last_aborted); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL full_done_pulses got=%0d want=1", done_cnt); end
        total++; if (beat_cyc.size() == 3 && (beat_cyc[2] - beat_cyc[0]) != 2) begin bad++; $display("FAIL full_throughput got=%0d want=2", beat_cyc[2] - beat_cyc[0]); end
        total++; if (beat_cyc.size() == 3 && (done_cyc - beat_cyc[2]) != 1) begin bad++; $display("FAIL full_done_latency got=%0d want=1", done_cyc - beat_cyc[2]); end
    endtask

    task automatic test_odd_tail();
        logic [31:0] w[3];
        logic [WIDTH:0] exp[3];
        bit seen;
        w   = '{32'hAAAA5555, 32'h12345678, 32'hDEADBBBB};
        exp = '{{1'b0, 32'hAAAA5555}, {1'b0, 32'h12345678}, {1'b1, 32'h0000BBBB}};
        hq.delete();
        clear_mon();
        for (int i = 0; i < 3; i++) push_word(w[i]);
        bus.out_ready = 1'b1;
        issue_req(5);
        wait_done(50, seen);
        total++; if (!seen) begin bad++; $display("FAIL odd_done_timeout got=0 want=1"); end
        cyc();
        cyc();
        total++; if (beats.size() != 3) begin bad++; $display("FAIL odd_beat_count got=%0d want=3", beats.size()); end
        for (int i = 0; i < 3; i++) begin
            total++; if (beats[i] !== exp[i]) begin bad++; $display("FAIL odd_beat%0d got=%h want=%h", i, beats[i], exp[i]); end
        end
        total++; if (n_full != 2 || n_half != 1) begin bad++; $display("FAIL odd_reads got=%0d/%0d want=2/1", n_full, n_half); end
        total++; if (last_xfer !== 16'd5) begin bad++; $display("FAIL odd_xfer got=%0d want=5", last_xfer); end
    endtask

    task automatic test_zero_req();
        clear_mon();
        issue_req(0);
        @(negedge clk);
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL zero_done got=%b want=1", bus.done); end
        total++; if (bus.aborted !== 1'b0) begin bad++; $display("FAIL zero_aborted got=%b want=0", bus.aborted); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL zero_busy got=%b want=0", bus.busy); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL zero_req_ready got=%b want=1", bus.req_ready); end
        cyc();
        @(negedge clk);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL zero_done_pulse got=%b want=0", bus.done); end
    endtask

    task automatic test_stall();
        logic [31:0] w[4];
        bit seen;
        w = '{32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003, 32'hC0DE0004};
        hq.delete();
        clear_mon();
        for (int i = 0; i < 4; i++) push_word(w[i]);
        bus.out_ready = 1'b1;
        issue_req(8);
        cyc();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (bus.fifo_read !== 1'b0) begin bad++; $display("FAIL stall_read%0d got=%b want=0", i, bus.fifo_read); end
            total++; if (bus.out_valid !== 1'b1 || bus.out_data !== w[0]) begin bad++; $display("FAIL stall_hold%0d got=%b/%h want=1/%h", i, bus.out_valid, bus.out_data, w[0]); end
            cyc();
        end
        bus.out_ready = 1'b1;
        wait_done(50, seen);
        total++; if (!seen) begin bad++; $display("FAIL stall_done_timeout got=0 want=1"); end
        cyc();
        cyc();
        total++; if (beats.size() != 4) begin bad++; $display("FAIL stall_beat_count got=%0d want=4", beats.size()); end
        for (int i = 0; i < 4; i++) begin
            total++; if (beats[i] !== {1'b0, w[i]}) begin bad++; $display("FAIL stall_beat%0d got=%h want=%h", i, beats[i], {1'b0, w[i]}); end
        end
        total++; if (n_full != 4) begin bad++; $display("FAIL stall_reads got=%0d want=4", n_full); end
        total++; if (last_xfer !== 16'd8) begin bad++; $display("FAIL stall_xfer got=%0d want=8", last_xfer); end
    endtask

    task automatic test_halfvalid_wait();
        bit seen;
        hq.delete();
        clear_mon();
        push_word(32'h0BAD0001);
        push_word(32'h0BAD0002);
        full_block    = 1'b1;
        bus.out_ready = 1'b1;
        issue_req(4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++; if (bus.fifo_read !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL hv_wait%0d got=read%b/busy%b want=read0/busy1", i, bus.fifo_read, bus.busy); end
            cyc();
        end
        full_block = 1'b0;
        @(negedge clk);
        total++; if (bus.fifo_read !== 1'b1 || bus.fifo_only_read_half !== 1'b0) begin bad++; $display("FAIL hv_resume got=%b/%b want=1/0", bus.fifo_read, bus.fifo_only_read_half); end
        wait_done(50, seen);
        total++; if (!seen) begin bad++; $display("FAIL hv_done_timeout got=0 want=1"); end
        cyc();
        cyc();
        total++; if (beats.size() != 2 || n_half != 0) begin bad++; $display("FAIL hv_beats got=%0d/%0d want=2/0", beats.size(), n_half); end
        total++; if (last_xfer !== 16'd4) begin bad++; $display("FAIL hv_xfer got=%0d want=4", last_xfer); end
    endtask

    task automatic test_abort();
        bit seen;
        hq.delete();
        clear_mon();
        for (int i = 0; i < 4; i++) push_word(32'hAB000000 | 32'(i));
        bus.out_ready = 1'b1;
        issue_req(8);
        cyc();
        bus.abort = 1'b1;
        @(negedge clk);
        total++; if (bus.fifo_read !== 1'b0) begin bad++; $display("FAIL abort_no_read got=%b want=0", bus.fifo_read); end
        cyc();
        bus.abort = 1'b0;
        wait_done(50, seen);
        total++; if (!seen) begin bad++; $display("FAIL abort_done_timeout got=0 want=1"); end
        cyc();
        cyc();
        total++; if (beats.size() != 1 || beats[0] !== {1'b0, 32'hAB000000}) begin bad++; $display("FAIL abort_beats got=%0d/%h want=1/0ab000000", beats.size(), beats[0]); end
        total++; if (n_full != 1) begin bad++; $display("FAIL abort_reads got=%0d want=1", n_full); end
        total++; if (last_aborted !== 1'b1) begin bad++; $display("FAIL abort_flag got=%b want=1", last_aborted); end
        total++; if (last_xfer !== 16'd2) begin bad++; $display("FAIL abort_xfer got=%0d want=2", last_xfer); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL abort_done_pulses got=%0d want=1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        hq.delete();
        clear_mon();
        for (int i = 0; i < 4; i++) push_word(32'h77000000 | 32'(i));
        bus.out_ready = 1'b0;
        issue_req(8);
        cyc();
        cyc();
        reset_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", bus.busy); end
        total++; if (bus.fifo_read !== 1'b0) begin bad++; $display("FAIL rmid_fifo_read got=%b want=0", bus.fifo_read); end
        cyc();
        reset_n = 1'b1;
        hq.delete();
        clear_mon();
        push_word(32'h600D0002);
        bus.out_ready = 1'b1;
        issue_req(2);
        wait_done(50, seen);
        total++; if (!seen) begin bad++; $display("FAIL rmid_done_timeout got=0 want=1"); end
        cyc();
        cyc();
        total++; if (beats.size() != 1 || beats[0] !== {1'b0, 32'h600D0002}) begin bad++; $display("FAIL rmid_beat got=%0d/%h want=1/600d0002", beats.size(), beats[0]); end
        total++; if (last_xfer !== 16'd2 || last_aborted !== 1'b0) begin bad++; $display("FAIL rmid_status got=%0d/%b want=2/0", last_xfer, last_aborted); end
    endtask

    initial begin
        reset_n           = 1'b0;
        bus.req_valid     = 1'b0;
        bus.req_halfwords = '0;
        bus.abort         = 1'b0;
        bus.out_ready     = 1'b1;
        bus.fifo_dataout  = '0;
        bus.fifo_valid    = 1'b0;
        bus.fifo_halfvalid = 1'b0;
        fifo_en           = 1'b1;
        full_block        = 1'b0;
        pop_n             = 0;
        clear_mon();

        test_reset();
        test_full_words();
        test_odd_tail();
        test_zero_req();
        test_stall();
        test_halfvalid_wait();
        test_abort();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
